// File: rtl/l2_cache_fill_queue_pkg.sv
// Shared L2 line geometry and fill-queue types used by the fill queue and its entry FIFO.
package l2_cache_fill_queue_pkg;

  localparam int CACHE_LINE_BYTES       = 64;
  localparam int CACHE_LINE_BITS        = CACHE_LINE_BYTES * 8;
  localparam int CACHE_LINE_OFFSET_BITS = $clog2(CACHE_LINE_BYTES);
  localparam int L2_REQ_ID_WIDTH        = 4;

  typedef logic [32-CACHE_LINE_OFFSET_BITS-1:0] cache_line_index_t;

  typedef struct packed {
    cache_line_index_t            addr;
    logic                         duplicate;
    logic [L2_REQ_ID_WIDTH-1:0]   id;
  } l2_fill_entry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    RESTART = 2'd3
  } fill_state_e;

  function automatic logic [31:0] lineByteAddr(input cache_line_index_t idx);
    return {idx, {CACHE_LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_fill_entry_fifo.sv
// Circular-buffer storage for pending fill-queue entries with a registered almost-full flag.
module l2_fill_entry_fifo #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             almost_full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic             almostFull_q, almostFull_d;
  logic             full;
  logic             doPush, doPop;

  assign empty_o       = (count_q == '0);
  assign full          = (count_q == FULL_COUNT);
  assign rdata_o       = mem_q[head_q];
  assign almost_full_o = almostFull_q;

  // A push at full is only accepted when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full || doPop);

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q + (AW+1)'(doPush) - (AW+1)'(doPop);
    if (doPop)  head_d = head_q + AW'(1);
    if (doPush) tail_d = tail_q + AW'(1);
    almostFull_d = (DEPTH - int'(count_d)) <= AF_MARGIN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      almostFull_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      almostFull_q <= almostFull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[tail_q] <= wdata_i;
  end

  assert property (@(posedge clk) disable iff (reset) !(push_i && full && !pop_i))
    else $error("fill queue push while full: entry dropped");

endmodule

// File: rtl/l2_cache_fill_queue.sv
// Fill queue between the L2 miss CAM and the pipeline arbiter: one line-fill burst at a time,
// filled lines and duplicate replays restarted in strict FIFO order.
module l2_cache_fill_queue
  import l2_cache_fill_queue_pkg::*;
#(
  parameter int QUEUE_SIZE         = 8,
  parameter int ALMOST_FULL_MARGIN = 3,
  parameter int REQ_ID_WIDTH       = L2_REQ_ID_WIDTH,
  parameter int BEATS              = CACHE_LINE_BITS / 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enqueue_en,
  input  cache_line_index_t           enqueue_addr,
  input  logic                        enqueue_duplicate,
  input  logic [REQ_ID_WIDTH-1:0]     enqueue_id,
  output logic                        queue_almost_full,
  output logic                        mem_read_valid,
  output logic [31:0]                 mem_read_addr,
  input  logic                        mem_read_ready,
  input  logic                        mem_data_valid,
  input  logic [31:0]                 mem_data,
  output logic                        restart_valid,
  output cache_line_index_t           restart_addr,
  output logic [REQ_ID_WIDTH-1:0]     restart_id,
  output logic                        restart_fill,
  output logic [CACHE_LINE_BITS-1:0]  restart_data,
  input  logic                        restart_ack
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  fill_state_e                 state_q, state_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [CACHE_LINE_BITS-1:0]  lineBuf_q, lineBuf_d;
  l2_fill_entry_t              pushEntry;
  l2_fill_entry_t              headEntry;
  logic                        queueEmpty;
  logic                        popReq;

  // The id field width comes from the package struct, so REQ_ID_WIDTH must match L2_REQ_ID_WIDTH.
  always_comb begin
    pushEntry.addr      = enqueue_addr;
    pushEntry.duplicate = enqueue_duplicate;
    pushEntry.id        = enqueue_id;
  end

  l2_fill_entry_fifo #(
    .WIDTH     ($bits(l2_fill_entry_t)),
    .DEPTH     (QUEUE_SIZE),
    .AF_MARGIN (ALMOST_FULL_MARGIN)
  ) entryFifo (
    .clk           (clk),
    .reset         (reset),
    .push_i        (enqueue_en),
    .wdata_i       (pushEntry),
    .pop_i         (popReq),
    .rdata_o       (headEntry),
    .empty_o       (queueEmpty),
    .almost_full_o (queue_almost_full)
  );

  // An empty queue lets an incoming non-duplicate start its read immediately; duplicates
  // always wait for the registered head so they never overtake their original fill.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    lineBuf_d = lineBuf_q;
    popReq    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!queueEmpty) begin
          state_d = headEntry.duplicate ? RESTART : ADDR;
        end else if (enqueue_en && !enqueue_duplicate) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (mem_read_ready) begin
          state_d = DATA;
          beat_d  = '0;
        end
      end
      DATA: begin
        if (mem_data_valid) begin
          lineBuf_d[32*beat_q +: 32] = mem_data;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) state_d = RESTART;
        end
      end
      RESTART: begin
        if (restart_ack) begin
          popReq  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      lineBuf_q <= '0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      lineBuf_q <= lineBuf_d;
    end
  end

  assign mem_read_valid = (state_q == ADDR);
  assign mem_read_addr  = lineByteAddr(headEntry.addr);

  assign restart_valid  = (state_q == RESTART);
  assign restart_addr   = headEntry.addr;
  assign restart_id     = headEntry.id;
  assign restart_fill   = !headEntry.duplicate;
  assign restart_data   = headEntry.duplicate ? '0 : lineBuf_q;

  assert property (@(posedge clk) disable iff (reset)
    (restart_valid && !restart_ack) |=> (restart_valid && $stable(restart_addr) &&
      $stable(restart_id) && $stable(restart_fill) && $stable(restart_data)))
    else $error("restart outputs changed while stalled");

  assert property (@(posedge clk) disable iff (reset)
    (mem_read_valid && !mem_read_ready) |=> (mem_read_valid && $stable(mem_read_addr)))
    else $error("memory read address changed before acceptance");

endmodule
